spi_word_deser: RTL and testbench

Parametrised SPI receive deserializer for the FIR-over-SPI front end. It is the successor to the fixed 12-bit serial-to-parallel register and adds four things: configurable word width and bit order, chip-select framing with a bit counter, a holding register with a valid/ack handshake, and overrun/frame-error reporting. It sits between the SCK edge detector, which supplies `pulse`, and the coefficient/sample loader.

---
 rtl/spi_pkg.sv | 16 +
 rtl/flex_counter.sv | 30 +++
 rtl/spi_word_deser.sv | 114 +++++++++++
 tb/tb_spi_word_deser.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI receive path.
// Used by the word deserializer and its bit counter.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    localparam int SPI_DEF_BITS = 12;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Modulo counter with synchronous clear and enable.
// Wraps to 0 after reaching rollover_val-1.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            if (count == rollover_val - ONE) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/spi_word_deser.sv
// SPI receive deserializer: CS framing, bit counting, holding
// register with valid/ack handshake, overrun and frame errors.
module spi_word_deser
    import spi_pkg::*;
#(
    parameter int   NUM_BITS  = SPI_DEF_BITS,
    parameter logic SHIFT_MSB = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mosi,
    input  logic                        pulse,
    input  logic                        cs_active,
    input  logic                        word_ack,
    input  logic                        clr_ovr,
    output logic [NUM_BITS-1:0]         word_out,
    output logic                        word_valid,
    output logic [cnt_w(NUM_BITS)-1:0]  bit_cnt,
    output logic                        overrun,
    output logic                        frame_err
);

    localparam int CW = cnt_w(NUM_BITS);
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);
    localparam logic [CW-1:0] ROLL = CW'(NUM_BITS);

    deser_state_t state, nxt;
    logic [NUM_BITS-1:0] sr, new_word;
    logic accept, complete, frame_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        accept    = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_active) nxt = SHIFT;
            end
            SHIFT: begin
                if (!cs_active) begin
                    nxt       = IDLE;
                    frame_end = 1'b1;
                end else begin
                    accept = pulse;
                end
            end
        endcase
        complete = accept && (bit_cnt == LAST);
        if (SHIFT_MSB) begin
            new_word = {sr[NUM_BITS-2:0], mosi};
        end else begin
            new_word = {mosi, sr[NUM_BITS-1:1]};
        end
    end

    flex_counter #(
        .WIDTH(CW)
    ) u_bit_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (frame_end),
        .count_en    (accept),
        .rollover_val(ROLL),
        .count       (bit_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (frame_end) begin
            sr <= '0;
        end else if (accept) begin
            sr <= new_word;
        end
    end

    // An ack in the completion cycle frees the slot for the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (complete) begin
            if (!word_valid || word_ack) begin
                word_out   <= new_word;
                word_valid <= 1'b1;
            end
        end else if (word_ack) begin
            word_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (complete && word_valid && !word_ack) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
            frame_err <= frame_end && (bit_cnt != '0);
        end
    end

endmodule

// File: tb/tb_spi_word_deser.sv
// Scoreboard bench: 12-bit MSB-first and 8-bit LSB-first instances
// share one serial stream and are checked against a word-level model.
module tb_spi_word_deser;

    logic clk = 1'b0;
    logic rst, mosi, pulse, cs_active, word_ack, clr_ovr;

    logic [11:0] w0;
    logic        v0, o0, f0;
    logic [3:0]  c0;
    logic [7:0]  w1;
    logic        v1, o1, f1;
    logic [3:0]  c1;

    always #5 clk = ~clk;

    spi_word_deser #(.NUM_BITS(12), .SHIFT_MSB(1'b1)) dut0 (
        .clk(clk), .rst(rst), .mosi(mosi), .pulse(pulse),
        .cs_active(cs_active), .word_ack(word_ack), .clr_ovr(clr_ovr),
        .word_out(w0), .word_valid(v0), .bit_cnt(c0),
        .overrun(o0), .frame_err(f0)
    );

    spi_word_deser #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut1 (
        .clk(clk), .rst(rst), .mosi(mosi), .pulse(pulse),
        .cs_active(cs_active), .word_ack(word_ack), .clr_ovr(clr_ovr),
        .word_out(w1), .word_valid(v1), .bit_cnt(c1),
        .overrun(o1), .frame_err(f1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per instance, bits are gathered into a word by
    // arithmetic and word-level handshake state is tracked directly.
    int          nb [2] = '{12, 8};
    bit          msb[2] = '{1'b1, 1'b0};
    int          m_cnt [2];
    logic [31:0] m_acc [2];
    bit          m_valid [2];
    bit          m_ovr [2];
    bit          m_ferr [2];
    bit          m_in_frame;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_acc[k] = 0; m_valid[k] = 0;
            m_ovr[k] = 0; m_ferr[k] = 0;
        end
        m_in_frame = 0;
        q0.delete();
        q1.delete();
    endtask

    // Entered at a negedge; drives one cycle of inputs and checks the
    // registered outputs at the following negedge.
    task automatic step(input logic p, input logic m, input logic cs,
                        input logic ack, input logic clr);
        logic [31:0] word;
        bit done;
        pulse = p; mosi = m; cs_active = cs; word_ack = ack; clr_ovr = clr;
        for (int k = 0; k < 2; k++) begin
            done = 0;
            word = 0;
            m_ferr[k] = 0;
            if (m_in_frame && !cs) begin
                m_ferr[k] = (m_cnt[k] != 0);
                m_cnt[k] = 0;
                m_acc[k] = 0;
            end else if (m_in_frame && p) begin
                if (msb[k]) m_acc[k] = (m_acc[k] << 1) | 32'(m);
                else        m_acc[k] = m_acc[k] | (32'(m) << m_cnt[k]);
                m_cnt[k]++;
                if (m_cnt[k] == nb[k]) begin
                    done = 1;
                    word = m_acc[k];
                    m_cnt[k] = 0;
                    m_acc[k] = 0;
                end
            end
            if (done) begin
                if (!m_valid[k] || ack) begin
                    m_valid[k] = 1;
                    if (k == 0) q0.push_back(word);
                    else        q1.push_back(word);
                end else begin
                    m_ovr[k] = 1;
                end
            end else if (ack) begin
                m_valid[k] = 0;
            end
            if (clr && !(done && m_valid[k] && !ack && m_ovr[k] && 0))
                if (!(done && !ack && m_valid[k] && word != 0 && 0)) ;
        end
        // Overrun: a new drop this cycle wins over clear.
        for (int k = 0; k < 2; k++) ;
        m_in_frame = cs;
        @(posedge clk);
        @(negedge clk);
        chk("bit_cnt0", int'(c0), m_cnt[0]);
        chk("bit_cnt1", int'(c1), m_cnt[1]);
        chk("valid0", int'(v0), int'(m_valid[0]));
        chk("valid1", int'(v1), int'(m_valid[1]));
        chk("overrun0", int'(o0), int'(m_ovr[0]));
        chk("overrun1", int'(o1), int'(m_ovr[1]));
        chk("frame_err0", int'(f0), int'(m_ferr[0]));
        chk("frame_err1", int'(f1), int'(m_ferr[1]));
    endtask

    // Overrun bookkeeping with clear, applied before each step.
    task automatic cyc(input logic p, input logic m, input logic cs,
                       input logic ack, input logic clr);
        bit set0, set1;
        set0 = m_in_frame && cs && p && (m_cnt[0] == nb[0] - 1) && m_valid[0] && !ack;
        set1 = m_in_frame && cs && p && (m_cnt[1] == nb[1] - 1) && m_valid[1] && !ack;
        if (clr && !set0) m_ovr[0] = 0;
        if (clr && !set1) m_ovr[1] = 0;
        step(p, m, cs, ack, clr);
    endtask

    task automatic send(input logic [31:0] d, input int n, input logic ack_last);
        logic [31:0] dv;
        dv = d;
        cyc(0, 0, 1, 0, 0);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(1, dv[i], 1, (i == 0) && ack_last, 0);
        end
    endtask

    task automatic end_frame();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    // Monitor: a load is visible when valid rises or stays high across
    // a cycle whose ack was taken.
    logic pv0, pa0, pv1, pa1;
    always @(posedge clk) begin
        pv0 <= v0; pa0 <= word_ack && v0;
        pv1 <= v1; pa1 <= word_ack && v1;
    end

    always @(negedge clk) begin
        if (!rst && v0 && (!pv0 || pa0)) begin
            if (q0.size() == 0) chk("unexpected_word0", int'(w0), -1);
            else chk("word0", int'(w0), int'(q0.pop_front()));
        end
        if (!rst && v1 && (!pv1 || pa1)) begin
            if (q1.size() == 0) chk("unexpected_word1", int'(w1), -1);
            else chk("word1", int'(w1), int'(q1.pop_front()));
        end
    end

    initial begin
        rst = 1'b1;
        mosi = 0; pulse = 0; cs_active = 0; word_ack = 0; clr_ovr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_word0", int'(w0), 0);
        chk("rst_valid0", int'(v0), 0);
        chk("rst_cnt0", int'(c0), 0);
        chk("rst_ovr0", int'(o0), 0);
        chk("rst_ferr0", int'(f0), 0);
        chk("rst_word1", int'(w1), 0);
        chk("rst_valid1", int'(v1), 0);
        chk("rst_cnt1", int'(c1), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) cyc(i[0], 1, 0, 0, 0);

        send(32'hA5C, 12, 0);
        chk("msb_word_A5C", int'(w0), 12'hA5C);
        chk("msb_cnt_after", int'(c0), 0);
        end_frame();
        cyc(0, 0, 0, 1, 0);

        send(32'b10001101, 8, 0);
        chk("lsb_word_B1", int'(w1), 8'hB1);
        end_frame();
        cyc(0, 0, 0, 1, 0);

        send(32'h123, 12, 0);
        send(32'h456, 12, 0);
        end_frame();
        chk("ovr_keep_123", int'(w0), 12'h123);
        chk("ovr_set", int'(o0), 1);
        cyc(0, 0, 0, 0, 1);
        chk("ovr_cleared", int'(o0), 0);
        cyc(0, 0, 0, 1, 0);
        chk("ack_clears_valid", int'(v0), 0);

        send(32'h123, 12, 0);
        send(32'h456, 12, 1);
        chk("collide_word", int'(w0), 12'h456);
        chk("collide_valid", int'(v0), 1);
        chk("collide_no_ovr", int'(o0), 0);
        end_frame();

        send(32'h1F, 5, 0);
        cyc(0, 0, 0, 0, 0);
        chk("abort_ferr", int'(f0), 1);
        chk("abort_keep", int'(w0), 12'h456);
        cyc(0, 0, 0, 1, 1);
        send(32'h3C9, 12, 0);
        end_frame();
        cyc(0, 0, 0, 1, 0);

        // Chip-select drop on the completing pulse ignores that bit.
        send(32'h7FF, 11, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Asynchronous reset mid-word.
        send(32'h15, 6, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_cnt", int'(c0), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(0, 2) != 0), 1'($urandom),
                1'($urandom_range(0, 40) != 0),
                1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 19) == 0));
        end
        end_frame();
        cyc(0, 0, 0, 0, 0);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
